// File: rtl/group_acc_mac.sv
// ---------------------------------------------------------------------------
// group_acc_mac
//
// GROUP_NB parallel signed multiply-accumulate lanes that share one
// valid/ready beat stream. Each lane multiplies its image operand by its
// kernel operand at full precision and adds the product into a per-lane
// accumulator. A beat flagged with `last` closes the running sum: the lane
// sums move to `result` and the accumulators restart from zero on the same
// edge, so the next beat opens a new sum without a bubble.
//
// Pipeline (all on the rising edge of clk):
//   S1  operands, last and valid registered            (*_p0)
//   S2  full-precision signed product registered       (*_p1)
//   S3  sign-extended product added into accumulator   (acc_p2, result)
//
// The pipeline stalls only when a closing beat waits in S2 while the
// previous result is still unclaimed (res_val && !res_rdy); in that case
// no register changes and rdy is driven low.
//
// Build option:
//   GROUP_ACC_MAC_SATURATE_EN  when defined, each accumulator add clamps to
//                              the signed ACC_WIDTH range and a sticky
//                              per-lane flag records any clamp; the flags
//                              are presented on res_ovf with the result.
//                              When undefined, sums wrap modulo
//                              2^ACC_WIDTH and res_ovf is constant 0.
//
// Parameters:
//   GROUP_NB   number of lanes
//   IMG_WIDTH  signed image operand width per lane
//   KER_WIDTH  signed kernel operand width per lane
//   ACC_WIDTH  signed accumulator width, at least IMG_WIDTH+KER_WIDTH+1
//
// Ports:
//   clk      clock
//   rst_n    synchronous active-low reset
//   ma       packed image operands, lane i at [i*IMG_WIDTH +: IMG_WIDTH]
//   mb       packed kernel operands, lane i at [i*KER_WIDTH +: KER_WIDTH]
//   val      beat valid
//   last     final beat of an accumulation (qualified by val)
//   rdy      beat accepted when val && rdy
//   result   packed lane sums, lane i at [i*ACC_WIDTH +: ACC_WIDTH]
//   res_val  result valid
//   res_rdy  downstream takes the result when res_val && res_rdy
//   res_ovf  per-lane saturation flags belonging to result
// ---------------------------------------------------------------------------
module group_acc_mac #(
    parameter int GROUP_NB  = 4,
    parameter int IMG_WIDTH = 16,
    parameter int KER_WIDTH = 8,
    parameter int ACC_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [GROUP_NB*IMG_WIDTH-1:0] ma,
    input  logic [GROUP_NB*KER_WIDTH-1:0] mb,
    input  logic                          val,
    input  logic                          last,
    output logic                          rdy,
    output logic [GROUP_NB*ACC_WIDTH-1:0] result,
    output logic                          res_val,
    input  logic                          res_rdy,
    output logic [GROUP_NB-1:0]           res_ovf
);

    localparam int PROD_W = IMG_WIDTH + KER_WIDTH;

    // Full-precision signed product. Both operands are sign-extended to the
    // product width first, so the low PROD_W bits of the multiply are exact.
    function automatic logic signed [PROD_W-1:0] mul_fn(
        input logic [IMG_WIDTH-1:0] a,
        input logic [KER_WIDTH-1:0] b
    );
        logic signed [PROD_W-1:0] ax;
        logic signed [PROD_W-1:0] bx;
        ax = {{KER_WIDTH{a[IMG_WIDTH-1]}}, a};
        bx = {{IMG_WIDTH{b[KER_WIDTH-1]}}, b};
        return ax * bx;
    endfunction

`ifdef GROUP_ACC_MAC_SATURATE_EN
    // One guard bit above the accumulator width exposes signed overflow.
    function automatic logic signed [ACC_WIDTH:0] wide_add_fn(
        input logic [ACC_WIDTH-1:0] acc,
        input logic [PROD_W-1:0]    p
    );
        logic signed [ACC_WIDTH:0] ax;
        logic signed [ACC_WIDTH:0] px;
        ax = {acc[ACC_WIDTH-1], acc};
        px = {{(ACC_WIDTH+1-PROD_W){p[PROD_W-1]}}, p};
        return ax + px;
    endfunction

    // Guard bit and top bit disagree exactly when the sum left the range.
    function automatic logic clamp_fn(input logic [ACC_WIDTH:0] s);
        return s[ACC_WIDTH] ^ s[ACC_WIDTH-1];
    endfunction

    function automatic logic signed [ACC_WIDTH-1:0] sat_fn(
        input logic [ACC_WIDTH:0] s
    );
        if (clamp_fn(s)) begin
            if (s[ACC_WIDTH]) begin
                return {1'b1, {(ACC_WIDTH-1){1'b0}}};
            end
            return {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
        return s[ACC_WIDTH-1:0];
    endfunction
`else
    // Plain two's-complement add; the carry out is dropped (wraps).
    function automatic logic signed [ACC_WIDTH-1:0] wrap_add_fn(
        input logic [ACC_WIDTH-1:0] acc,
        input logic [PROD_W-1:0]    p
    );
        logic signed [ACC_WIDTH-1:0] px;
        px = {{(ACC_WIDTH-PROD_W){p[PROD_W-1]}}, p};
        return acc + px;
    endfunction
`endif

    logic                          stall;
    logic                          accept;

    logic                          vld_p0;
    logic                          last_p0;
    logic [GROUP_NB*IMG_WIDTH-1:0] ma_p0;
    logic [GROUP_NB*KER_WIDTH-1:0] mb_p0;

    logic                          vld_p1;
    logic                          last_p1;
    logic [GROUP_NB*PROD_W-1:0]    prod_p1;

    logic [GROUP_NB*ACC_WIDTH-1:0] acc_p2;

    logic [GROUP_NB*PROD_W-1:0]    prod_nx;
    logic [GROUP_NB*ACC_WIDTH-1:0] acc_nx;
    logic                          close_p1;

    // A closing beat in S2 can only move once the current result is gone.
    always_comb begin
        close_p1 = vld_p1 && last_p1;
        stall    = res_val && !res_rdy && close_p1;
        rdy      = !stall;
        accept   = val && rdy;
    end

`ifdef GROUP_ACC_MAC_SATURATE_EN
    logic [GROUP_NB-1:0] clamp_nx;
    logic [GROUP_NB-1:0] ovf_p2;
`endif

    for (genvar gi = 0; gi < GROUP_NB; gi++) begin : g_lane
        assign prod_nx[gi*PROD_W +: PROD_W] =
            mul_fn(ma_p0[gi*IMG_WIDTH +: IMG_WIDTH], mb_p0[gi*KER_WIDTH +: KER_WIDTH]);
`ifdef GROUP_ACC_MAC_SATURATE_EN
        logic signed [ACC_WIDTH:0] sum_w;
        assign sum_w = wide_add_fn(acc_p2[gi*ACC_WIDTH +: ACC_WIDTH],
                                   prod_p1[gi*PROD_W +: PROD_W]);
        assign acc_nx[gi*ACC_WIDTH +: ACC_WIDTH] = sat_fn(sum_w);
        assign clamp_nx[gi] = clamp_fn(sum_w);
`else
        assign acc_nx[gi*ACC_WIDTH +: ACC_WIDTH] =
            wrap_add_fn(acc_p2[gi*ACC_WIDTH +: ACC_WIDTH], prod_p1[gi*PROD_W +: PROD_W]);
`endif
    end

    // ---- S1: operand capture ------------------------------------------------
    always_ff @(posedge clk) begin
        if (!stall && accept) begin
            ma_p0 <= ma;
            mb_p0 <= mb;
        end
    end

    // ---- S2: product register -----------------------------------------------
    always_ff @(posedge clk) begin
        if (!stall && vld_p0) begin
            prod_p1 <= prod_nx;
        end
    end

    // ---- control for all stages and S3: accumulate / close ------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p0  <= 1'b0;
            last_p0 <= 1'b0;
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
            acc_p2  <= '0;
            result  <= '0;
            res_val <= 1'b0;
        end else if (!stall) begin
            vld_p0  <= accept;
            last_p0 <= accept && last;
            vld_p1  <= vld_p0;
            last_p1 <= vld_p0 && last_p0;
            if (close_p1) begin
                // Closing beat: hand the sum over and restart at zero.
                result  <= acc_nx;
                acc_p2  <= '0;
                res_val <= 1'b1;
            end else begin
                if (vld_p1) begin
                    acc_p2 <= acc_nx;
                end
                if (res_rdy) begin
                    res_val <= 1'b0;
                end
            end
        end
    end

`ifdef GROUP_ACC_MAC_SATURATE_EN
    // Sticky clamp flags follow the accumulator lifetime exactly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_p2  <= '0;
            res_ovf <= '0;
        end else if (!stall && vld_p1) begin
            if (last_p1) begin
                res_ovf <= ovf_p2 | clamp_nx;
                ovf_p2  <= '0;
            end else begin
                ovf_p2  <= ovf_p2 | clamp_nx;
            end
        end
    end
`else
    assign res_ovf = '0;
`endif

endmodule

// File: tb/tb_group_acc_mac.sv
// ---------------------------------------------------------------------------
// tb_group_acc_mac
//
// Bench for group_acc_mac. A default-parameter instance carries most
// scenarios; a second instance with ACC_WIDTH=25 exercises the
// overflow/wrap boundary. Expected sums come from a lane-by-lane integer
// model of multiply-accumulate, with clamping or modulo wrap selected by
// GROUP_ACC_MAC_SATURATE_EN.
// ---------------------------------------------------------------------------
module tb_group_acc_mac;

    localparam longint MAXV = 2147483647;
    localparam longint MINV = -MAXV - 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [63:0]  ma;
    logic [31:0]  mb;
    logic         val, last, rdy, res_val, res_rdy;
    logic [127:0] result;
    logic [3:0]   res_ovf;

    logic [63:0]  ma2;
    logic [31:0]  mb2;
    logic         val2, last2, rdy2, res_val2, res_rdy2;
    logic [99:0]  result2;
    logic [3:0]   res_ovf2;

    always #5 clk = ~clk;

    group_acc_mac dut (
        .clk(clk), .rst_n(rst_n), .ma(ma), .mb(mb), .val(val), .last(last),
        .rdy(rdy), .result(result), .res_val(res_val), .res_rdy(res_rdy),
        .res_ovf(res_ovf)
    );

    group_acc_mac #(.ACC_WIDTH(25)) dut25 (
        .clk(clk), .rst_n(rst_n), .ma(ma2), .mb(mb2), .val(val2), .last(last2),
        .rdy(rdy2), .result(result2), .res_val(res_val2), .res_rdy(res_rdy2),
        .res_ovf(res_ovf2)
    );

    typedef struct {
        logic [127:0] r;
        logic [3:0]   o;
        int           c;
    } res_t;

    int     n_checks = 0;
    int     n_fail   = 0;
    int     cyc      = 0;
    res_t   obs_q[$];
    res_t   exp_q[$];
    longint m_sum[4];
    logic [3:0] m_flag;

    always @(posedge clk) cyc <= cyc + 1;

    // Every result handed over downstream, with the cycle of the handshake.
    always @(negedge clk) begin
        res_t e;
        if (rst_n && res_val && res_rdy) begin
            e.r = result;
            e.o = res_ovf;
            e.c = cyc;
            obs_q.push_back(e);
        end
    end

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m_sum[i] = 0;
        m_flag = '0;
    endtask

    task automatic model_beat(input logic [63:0] a, input logic [31:0] b, input logic l);
        longint p, s;
        logic [63:0] t;
        res_t e;
        for (int i = 0; i < 4; i++) begin
            p = longint'($signed(a[i*16 +: 16])) * longint'($signed(b[i*8 +: 8]));
            s = m_sum[i] + p;
`ifdef GROUP_ACC_MAC_SATURATE_EN
            if (s > MAXV) begin
                s = MAXV;
                m_flag[i] = 1'b1;
            end else if (s < MINV) begin
                s = MINV;
                m_flag[i] = 1'b1;
            end
`else
            t = s;
            s = longint'(int'(t[31:0]));
`endif
            m_sum[i] = s;
        end
        if (l) begin
            for (int i = 0; i < 4; i++) begin
                t = m_sum[i];
                e.r[i*32 +: 32] = t[31:0];
            end
            e.o = m_flag;
            e.c = 0;
            exp_q.push_back(e);
            model_clear();
        end
    endtask

    task automatic clear_all();
        model_clear();
        obs_q.delete();
        exp_q.delete();
    endtask

    // Present one beat starting at posedge+1; returns at posedge+1 after it
    // has been accepted.
    task automatic drive_beat(input logic [63:0] a, input logic [31:0] b, input logic l);
        logic got;
        ma = a; mb = b; last = l; val = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 200 && !got; t++) begin
            @(negedge clk);
            got = rdy;
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL drive_accept: beat not accepted, rdy=%b required 1", rdy);
        end else begin
            model_beat(a, b, l);
        end
        val = 1'b0; last = 1'b0;
    endtask

    task automatic wait_results(input int n);
        int t;
        t = 0;
        while (obs_q.size() < n && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        n_checks++;
        if (obs_q.size() < n) begin
            n_fail++;
            $display("FAIL wait_results: got %0d results, required %0d", obs_q.size(), n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; val = 1'b1; last = 1'b1; res_rdy = 1'b1;
        ma = {$urandom, $urandom}; mb = $urandom;
        val2 = 1'b1; last2 = 1'b1; res_rdy2 = 1'b1;
        ma2 = {$urandom, $urandom}; mb2 = $urandom;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1; val = 1'b0; last = 1'b0; val2 = 1'b0; last2 = 1'b0;
        @(negedge clk);
        n_checks++;
        if (res_val !== 1'b0) begin n_fail++; $display("FAIL reset_res_val: got %b required 0", res_val); end
        n_checks++;
        if (result !== 128'd0) begin n_fail++; $display("FAIL reset_result: got %h required 0", result); end
        n_checks++;
        if (res_ovf !== 4'd0) begin n_fail++; $display("FAIL reset_res_ovf: got %b required 0", res_ovf); end
        n_checks++;
        if (rdy !== 1'b1) begin n_fail++; $display("FAIL reset_rdy: got %b required 1", rdy); end
        n_checks++;
        if (res_val2 !== 1'b0) begin n_fail++; $display("FAIL reset_res_val25: got %b required 0", res_val2); end
        @(posedge clk);
        #1;
    endtask

    task automatic send_ramp();
        logic [63:0] a;
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 4; i++) a[i*16 +: 16] = 16'((4*k + i + 1) << 4);
            drive_beat(a, {4{8'h08}}, k == 4);
        end
    endtask

    task automatic test_basic();
        logic [127:0] want;
        want = {32'd7680, 32'd7040, 32'd6400, 32'd5760};
        clear_all();
        res_rdy = 1'b1;
        send_ramp();
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (res_val !== (k == 3)) begin
                n_fail++;
                $display("FAIL basic_latency_c%0d: res_val=%b required %b", k, res_val, (k == 3));
            end
        end
        n_checks++;
        if (result !== want) begin n_fail++; $display("FAIL basic_result: got %h required %h", result, want); end
        n_checks++;
        if (exp_q.size() != 1 || exp_q[0].r !== want) begin
            n_fail++; $display("FAIL basic_model: model queue size %0d, required one entry %h", exp_q.size(), want);
        end
        n_checks++;
        if (res_ovf !== 4'd0) begin n_fail++; $display("FAIL basic_ovf: got %b required 0", res_ovf); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        clear_all();
        res_rdy = 1'b0;
        send_ramp();
        for (int k = 0; k < 5; k++) drive_beat({$urandom, $urandom}, $urandom, k == 4);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_checks++;
            if (res_val !== 1'b1 || result !== exp_q[0].r) begin
                n_fail++;
                $display("FAIL bp_hold_c%0d: res_val=%b result=%h required 1 %h", k, res_val, result, exp_q[0].r);
            end
            n_checks++;
            if (rdy !== (k == 0)) begin
                n_fail++; $display("FAIL bp_rdy_c%0d: got %b required %b", k, rdy, (k == 0));
            end
        end
        @(posedge clk);
        #1;
        res_rdy = 1'b1;
        @(negedge clk);
        n_checks++;
        if (result !== exp_q[0].r) begin n_fail++; $display("FAIL bp_release_first: got %h required %h", result, exp_q[0].r); end
        @(negedge clk);
        n_checks++;
        if (res_val !== 1'b1 || result !== exp_q[1].r || rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_second: res_val=%b rdy=%b result=%h required 1 1 %h", res_val, rdy, result, exp_q[1].r);
        end
        @(posedge clk);
        #1;
        drive_beat({$urandom, $urandom}, $urandom, 1'b1);
        wait_results(3);
        for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i].r !== exp_q[i].r) begin
                n_fail++; $display("FAIL bp_seq%0d: got %h required %h", i, obs_q[i].r, exp_q[i].r);
            end
        end
        n_checks++;
        if (obs_q.size() >= 2 && obs_q[1].c - obs_q[0].c != 1) begin
            n_fail++; $display("FAIL bp_gap: second result %0d cycles after first, required 1", obs_q[1].c - obs_q[0].c);
        end
    endtask

    task automatic test_back_to_back();
        clear_all();
        res_rdy = 1'b1;
        for (int k = 0; k < 4; k++) drive_beat({4{16'h0010}}, {4{8'h10}}, 1'b1);
        wait_results(4);
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (obs_q.size() != 4) begin n_fail++; $display("FAIL b2b_count: got %0d required 4", obs_q.size()); end
        for (int i = 0; i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i].r !== {4{32'd256}}) begin
                n_fail++; $display("FAIL b2b_value%0d: got %h required %h", i, obs_q[i].r, {4{32'd256}});
            end
            if (i > 0) begin
                n_checks++;
                if (obs_q[i].c - obs_q[i-1].c != 1) begin
                    n_fail++; $display("FAIL b2b_gap%0d: got %0d cycles required 1", i, obs_q[i].c - obs_q[i-1].c);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_all();
        res_rdy = 1'b1;
        drive_beat({$urandom, $urandom}, $urandom, 1'b0);
        drive_beat({$urandom, $urandom}, $urandom, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_clear();
        drive_beat({4{16'h0010}}, {4{8'h08}}, 1'b1);
        wait_results(1);
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (obs_q.size() != 1) begin n_fail++; $display("FAIL rstmid_count: got %0d required 1", obs_q.size()); end
        n_checks++;
        if (obs_q.size() > 0 && obs_q[0].r !== {4{32'd128}}) begin
            n_fail++; $display("FAIL rstmid_value: got %h required %h", obs_q[0].r, {4{32'd128}});
        end
    endtask

    task automatic test_negative();
        clear_all();
        res_rdy = 1'b1;
        for (int k = 0; k < 3; k++) drive_beat({4{16'hFFF0}}, {4{8'h08}}, k == 2);
        wait_results(1);
        n_checks++;
        if (obs_q.size() > 0 && (obs_q[0].r !== {4{32'hFFFF_FE80}} || obs_q[0].o !== 4'd0)) begin
            n_fail++; $display("FAIL negative: got %h ovf %b required %h ovf 0", obs_q[0].r, obs_q[0].o, {4{32'hFFFF_FE80}});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        logic done;
        int   len;
        clear_all();
        done = 1'b0;
        fork
            begin
                for (int s = 0; s < 30; s++) begin
                    len = $urandom_range(1, 4);
                    for (int k = 0; k < len; k++) begin
                        drive_beat({$urandom, $urandom}, $urandom, k == len - 1);
                        if ($urandom_range(0, 3) == 0) begin
                            @(posedge clk);
                            #1;
                        end
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    res_rdy = ($urandom_range(0, 2) != 0);
                end
            end
        join
        res_rdy = 1'b1;
        wait_results(exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i].r !== exp_q[i].r || obs_q[i].o !== exp_q[i].o) begin
                n_fail++;
                $display("FAIL random%0d: got %h ovf %b required %h ovf %b", i, obs_q[i].r, obs_q[i].o, exp_q[i].r, exp_q[i].o);
            end
        end
    endtask

    task automatic test_width25();
        logic signed [24:0] want;
        logic [3:0]         want_ovf;
        logic               got;
        int                 t;
`ifdef GROUP_ACC_MAC_SATURATE_EN
        want = 25'sd16777215;
        want_ovf = 4'b1111;
`else
        want = -25'sd12747387;
        want_ovf = 4'b0000;
`endif
        res_rdy2 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            ma2 = {4{16'h7FFF}}; mb2 = {4{8'h7F}}; val2 = 1'b1; last2 = (k == 4);
            got = 1'b0;
            for (int w = 0; w < 50 && !got; w++) begin
                @(negedge clk);
                got = rdy2;
                @(posedge clk);
                #1;
            end
            n_checks++;
            if (!got) begin n_fail++; $display("FAIL w25_accept%0d: rdy=%b required 1", k, rdy2); end
        end
        val2 = 1'b0; last2 = 1'b0;
        t = 0;
        @(negedge clk);
        while (!res_val2 && t < 20) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (res_val2 !== 1'b1) begin n_fail++; $display("FAIL w25_res_val: got %b required 1", res_val2); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (result2[i*25 +: 25] !== want) begin
                n_fail++; $display("FAIL w25_lane%0d: got %0d required %0d", i, $signed(result2[i*25 +: 25]), want);
            end
        end
        n_checks++;
        if (res_ovf2 !== want_ovf) begin n_fail++; $display("FAIL w25_ovf: got %b required %b", res_ovf2, want_ovf); end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; val = 1'b0; last = 1'b0; res_rdy = 1'b1; ma = '0; mb = '0;
        val2 = 1'b0; last2 = 1'b0; res_rdy2 = 1'b1; ma2 = '0; mb2 = '0;
        model_clear();
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_negative();
        test_random();
        test_width25();
        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/group_acc_mac.md
GROUP_ACC_MAC -- requirements
Module: group_acc_mac

Interface
REQ-001 SHALL have parameter GROUP_NB, default 4, number of parallel MAC lanes.
REQ-002 SHALL have parameter IMG_WIDTH, default 16, signed image operand width per lane.
REQ-003 SHALL have parameter KER_WIDTH, default 8, signed kernel operand width per lane.
REQ-004 SHALL have parameter ACC_WIDTH, default 32, signed accumulator/result width per lane; legal values are at least IMG_WIDTH+KER_WIDTH+1.
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-007 SHALL have port ma, input, GROUP_NB*IMG_WIDTH, packed signed image operands; lane i at [i*IMG_WIDTH +: IMG_WIDTH].
REQ-008 SHALL have port mb, input, GROUP_NB*KER_WIDTH, packed signed kernel operands; same lane packing.
REQ-009 SHALL have port val, input, 1, beat valid.
REQ-010 SHALL have port last, input, 1, marks final beat of an accumulation; qualified by val.
REQ-011 SHALL have port rdy, output, 1, beat accepted when val && rdy.
REQ-012 SHALL have port result, output, GROUP_NB*ACC_WIDTH, packed signed lane sums.
REQ-013 SHALL have port res_val, output, 1, result valid.
REQ-014 SHALL have port res_rdy, input, 1, downstream accepts result when res_val && res_rdy.
REQ-015 SHALL have port res_ovf, output, GROUP_NB, per-lane saturation flag for the presented result.

Function
REQ-016 SHALL be a 3-stage pipeline: S1 registers operands/last, S2 registers full-precision signed product (IMG_WIDTH+KER_WIDTH bits), S3 adds sign-extended product into lane accumulator.
REQ-017 SHALL, on an accepted beat with last=1, load result = accumulator + that beat's product and set res_val exactly 3 cycles after acceptance when not stalled.
REQ-018 SHALL clear every lane accumulator to 0 in the same cycle a last beat's sum is transferred to result, so the next beat starts a new sum with no bubble.
REQ-019 SHALL hold result, res_ovf, res_val stable while res_val && !res_rdy.
REQ-020 SHALL stall all stages (no register update) when res_val && !res_rdy && a last beat is in S3; rdy SHALL be 0 during stall, else 1.
REQ-021 SHALL allow simultaneous result consumption and new result load in one cycle (no bubble between back-to-back last beats).
REQ-022 SHALL treat beats without val as bubbles that do not alter accumulators.
REQ-023 SHALL treat a single beat with last=1 as a complete one-term accumulation.
REQ-024 SHALL, without saturation, wrap accumulator arithmetic modulo 2^ACC_WIDTH.

Reset
REQ-025 SHALL, on clk edge with rst_n=0, clear all pipeline valids, accumulators, result, res_ovf to 0 and res_val to 0; rdy SHALL be 1 from the first cycle after reset.
REQ-026 SHALL discard any partial accumulation and in-flight beats when reset occurs mid-operation.

Configuration
REQ-027 SHALL support macro GROUP_ACC_MAC_SATURATE_EN.
REQ-028 SHALL, with GROUP_ACC_MAC_SATURATE_EN defined, clamp each accumulator add to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1], set a sticky per-lane flag on any clamp, copy it to res_ovf with the result, and clear it with the accumulator.
REQ-029 SHALL, without the macro, wrap per REQ-024 and tie res_ovf to 0.

Verification
REQ-030 SHALL test defaults, res_rdy=1, mb lanes all 0x08 (0.5), five beats ma lanes {1..4},{5..8},{9..12},{13..16},{17..20} (Q.4), last on fifth -> res_val 3 cycles after fifth beat, lanes 0..3 = 5760, 6400, 7040, 7680.
REQ-031 SHALL test backpressure: same stimulus, res_rdy=0 for 10 cycles, second sequence following -> result held, rdy=0 while second last is in S3, second result appears one cycle after res_rdy=1, no beat lost.
REQ-032 SHALL test back-to-back single-beat last: ma lanes 0x0010, mb 0x10, val=last=1 for 4 cycles -> four consecutive res_val cycles, each lane 256.
REQ-033 SHALL test reset mid-sum: two beats accepted, rst_n=0 for 1 cycle, then one last beat ma=0x0010, mb=0x08 -> result lanes 128, no earlier contribution.
REQ-034 SHALL test ACC_WIDTH=25: five beats ma=0x7FFF, mb=0x7F, last on fifth -> with macro each lane 16777215 and res_ovf=4'b1111; without macro each lane -12747387 and res_ovf=0.
REQ-035 SHALL test negative operands: ma=0xFFF0 (-1.0), mb=0x08, 3 beats -> each lane -384.
